// File: rtl/fp16_pkg.sv
// Shared constants and types for the fp16 add/sub datapath.
// Widths here describe the extended mantissa format handed to rounding.
package fp16_pkg;

    localparam int EXPONENT = 5;
    localparam int MANTISSA = 10;
    localparam int DWIDTH   = 16;

    // Extended mantissa: hidden bit, 10 fraction bits, guard, round, 3 sticky.
    localparam int EXT_MW  = 16;
    localparam int EXP_MAX = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } norm_state_e;

endpackage : fp16_pkg

// File: rtl/fp_normalize.sv
// Iterative post-add normaliser: one left shift per cycle until the hidden bit
// reaches MW-1 or the exponent floor is hit; carry-out is handled at capture.
module fp_normalize
    import fp16_pkg::*;
#(
    parameter int MW = EXT_MW,
    parameter int EW = EXPONENT
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_s,
    input  logic [MW:0]   in_m,
    input  logic [EW-1:0] in_e,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_s,
    output logic [MW-1:0] a_m_shift,
    output logic [EW-1:0] z_e,
    output logic          out_zero,
    output logic          out_ovf
);

    localparam logic [EW-1:0] E_MAX = {EW{1'b1}};
    localparam logic [EW-1:0] E_ONE = EW'(1);

    norm_state_e   state_q, state_d;
    logic [MW-1:0] m_q, m_d;
    logic [EW-1:0] e_q, e_d;
    logic [EW-1:0] z_e_q, z_e_d;
    logic          s_q, s_d;
    logic          zero_q, zero_d;
    logic          ovf_q, ovf_d;

    logic [EW:0]   e_inc;
    logic [MW-1:0] m_shl;
    logic [EW-1:0] e_dec;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
        state_d = state_q;
        m_d     = m_q;
        e_d     = e_q;
        z_e_d   = z_e_q;
        s_d     = s_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        // One bit wider than the exponent so the carry increment cannot wrap.
        e_inc = {1'b0, in_e} + {{EW{1'b0}}, 1'b1};
        m_shl = {m_q[MW-2:0], 1'b0};
        e_dec = (e_q > E_ONE) ? (e_q - E_ONE) : e_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d    = in_s;
                    zero_d = 1'b0;
                    ovf_d  = 1'b0;
                    if (in_m == '0) begin
                        m_d     = '0;
                        z_e_d   = '0;
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else if (in_m[MW]) begin
                        if (e_inc >= {1'b0, E_MAX}) begin
                            ovf_d = 1'b1;
                            z_e_d = E_MAX;
                            m_d   = '0;
                        end else begin
                            // The bit shifted out folds into the sticky position.
                            m_d   = {in_m[MW:2], in_m[1] | in_m[0]};
                            z_e_d = e_inc[EW-1:0];
                        end
                        state_d = DONE;
                    end else if (in_m[MW-1]) begin
                        m_d     = in_m[MW-1:0];
                        z_e_d   = in_e;
                        state_d = DONE;
                    end else if (in_e <= E_ONE) begin
                        m_d     = in_m[MW-1:0];
                        z_e_d   = '0;
                        state_d = DONE;
                    end else begin
                        m_d     = in_m[MW-1:0];
                        e_d     = in_e;
                        state_d = NORM;
                    end
                end
            end

            NORM: begin
                m_d = m_shl;
                e_d = e_dec;
                if (m_shl[MW-1]) begin
                    z_e_d   = e_dec;
                    state_d = DONE;
                end else if (e_dec == E_ONE) begin
                    // Floor reached before the hidden bit: deliver as subnormal.
                    z_e_d   = '0;
                    state_d = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the whole datapath is small, so every register is async-reset to give all-zero outputs immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            m_q     <= '0;
            e_q     <= '0;
            z_e_q   <= '0;
            s_q     <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            m_q     <= m_d;
            e_q     <= e_d;
            z_e_q   <= z_e_d;
            s_q     <= s_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_s     = s_q;
    assign a_m_shift = m_q;
    assign z_e       = z_e_q;
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;

endmodule : fp_normalize

// File: tb/tb_fp_normalize.sv
// Directed and random bench for fp_normalize: expected results are queued on
// issue and compared, with latency, when out_valid appears.
module tb_fp_normalize;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic        in_s;
    logic [16:0] in_m;
    logic [4:0]  in_e;
    logic        out_valid;
    logic        out_ready;
    logic        out_s;
    logic [15:0] a_m_shift;
    logic [4:0]  z_e;
    logic        out_zero;
    logic        out_ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] m;
        logic [4:0]  e;
        logic        s;
        logic        zero;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];

    fp_normalize dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_m      (in_m),
        .in_e      (in_e),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .a_m_shift (a_m_shift),
        .z_e       (z_e),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] m, input logic [4:0] e, input logic s,
                                input logic zero, input logic ovf, input int lat);
        exp_t r;
        r.m = m; r.e = e; r.s = s; r.zero = zero; r.ovf = ovf; r.lat = lat;
        return r;
    endfunction

    // Reference behaviour written as a leading-zero walk rather than a state machine.
    function automatic exp_t model(input logic [16:0] m, input logic [4:0] e, input logic s);
        exp_t        r;
        logic [15:0] mm;
        int          ee;
        r = mk(16'h0, 5'd0, s, 1'b0, 1'b0, 1);
        if (m == 17'h0) begin
            r.zero = 1'b1;
        end else if (m[16]) begin
            ee = int'(e) + 1;
            if (ee >= 31) begin
                r.ovf = 1'b1;
                r.e   = 5'd31;
            end else begin
                r.m = m[16:1] | {15'h0, m[0]};
                r.e = 5'(ee);
            end
        end else begin
            mm = m[15:0];
            ee = int'(e);
            while (!mm[15] && ee > 1) begin
                mm = mm << 1;
                ee--;
                r.lat++;
            end
            r.m = mm;
            r.e = mm[15] ? 5'(ee) : 5'd0;
        end
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [16:0] m, input logic [4:0] e,
                          input logic s, input exp_t x, input int hold, input bit junk);
        exp_t got;
        int   lat;
        sb.push_back(x);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_m      = m;
        in_e      = e;
        in_s      = s;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (junk) begin
                in_m = 17'($urandom);
                in_e = 5'($urandom);
                in_s = ~s;
            end else begin
                in_valid = 1'b0;
            end
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        got = sb.pop_front();
        check({tag, "_lat"}, 32'(lat), 32'(got.lat));
        check({tag, "_m"}, 32'(a_m_shift), 32'(got.m));
        check({tag, "_e"}, 32'(z_e), 32'(got.e));
        check({tag, "_s"}, 32'(out_s), 32'(got.s));
        check({tag, "_zero"}, 32'(out_zero), 32'(got.zero));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(got.ovf));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
                check({tag, "_hold_out"}, {10'h0, a_m_shift, z_e, out_zero},
                      {10'h0, got.m, got.e, got.zero});
            end
            out_ready = 1'b1;
            @(negedge clk);
            check({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
            check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [16:0] rm;
        logic [4:0]  re;
        logic        rs;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_s      = 1'b0;
        in_m      = '0;
        in_e      = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outs", {8'h0, out_s, a_m_shift, z_e, out_zero, out_ovf}, 32'h0);
        resetn = 1'b1;

        run_op("normd", 17'h08000, 5'd15, 1'b0, mk(16'h8000, 5'd15, 1'b0, 1'b0, 1'b0, 1), 0, 1'b0);
        run_op("long", 17'h00100, 5'd20, 1'b1, mk(16'h8000, 5'd13, 1'b1, 1'b0, 1'b0, 8), 0, 1'b0);
        run_op("carry", 17'h10001, 5'd10, 1'b0, mk(16'h8001, 5'd11, 1'b0, 1'b0, 1'b0, 1), 0, 1'b0);
        run_op("ovf", 17'h10000, 5'd30, 1'b1, mk(16'h0000, 5'd31, 1'b1, 1'b0, 1'b1, 1), 0, 1'b0);
        run_op("ovf31", 17'h1FFFF, 5'd31, 1'b0, mk(16'h0000, 5'd31, 1'b0, 1'b0, 1'b1, 1), 0, 1'b0);
        run_op("carry0", 17'h10002, 5'd0, 1'b0, mk(16'h8001, 5'd1, 1'b0, 1'b0, 1'b0, 1), 0, 1'b0);
        run_op("floor", 17'h00400, 5'd3, 1'b0, mk(16'h1000, 5'd0, 1'b0, 1'b0, 1'b0, 3), 0, 1'b0);
        run_op("sub1", 17'h00123, 5'd1, 1'b1, mk(16'h0123, 5'd0, 1'b1, 1'b0, 1'b0, 1), 0, 1'b0);
        run_op("max15", 17'h00001, 5'd20, 1'b0, mk(16'h8000, 5'd5, 1'b0, 1'b0, 1'b0, 16), 0, 1'b1);
        run_op("zero", 17'h00000, 5'd9, 1'b1, mk(16'h0000, 5'd0, 1'b1, 1'b1, 1'b0, 1), 5, 1'b0);

        // Reset in the middle of a long normalisation.
        @(negedge clk);
        in_valid = 1'b1;
        in_m     = 17'h00100;
        in_e     = 5'd20;
        in_s     = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midnorm_valid", 32'(out_valid), 32'd0);
        check("midnorm_ready", 32'(in_ready), 32'd0);
        #2 resetn = 1'b0;
        #1;
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_outs", {8'h0, out_s, a_m_shift, z_e, out_zero, out_ovf}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        run_op("after_rst", 17'h00100, 5'd20, 1'b1, mk(16'h8000, 5'd13, 1'b1, 1'b0, 1'b0, 8), 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            rm = 17'($urandom);
            rm = rm >> $urandom_range(0, 16);
            re = 5'($urandom);
            rs = 1'($urandom);
            run_op($sformatf("rnd%0d", i), rm, re, rs, model(rm, re, rs), 0, 1'b0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fp_normalize
